hsv_stream_ctrl: RTL
====================

HSV_STREAM_CTRL -- requirements
Module: hsv_stream_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMAGE_W, 640, pixels per line.
- IMAGE_H, 480, lines per frame.
- CORE_LAT, 3, enabled-cycle latency of the external HSV core; legal range 1..8.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- sink_data/sink_valid/sink_sop/sink_eop, in, 24/1/1/1, Avalon-ST RGB input.
- sink_ready, out, 1, input backpressure.
- source_data/source_valid/source_sop/source_eop, out, 24/1/1/1, Avalon-ST output.
- source_ready, in, 1, output backpressure.
- core_en, out, 1, advance enable for the external core pipeline.
- core_in_data, out, 24, RGB to the core; equals sink_data.
- core_out_data, in, 24, HSV from the core, CORE_LAT enabled cycles after input.
- cfg_enable, in, 1, 1 = convert video pixels, 0 = pass-through.
- frame_done, out, 1, one-cycle pulse at video eop.
- frame_err, out, 1, one-cycle pulse on a malformed video packet.

Function
REQ-003 The block SHALL hold a CORE_LAT-deep sideband pipe; each stage holds valid, sop, eop, bypass and 24-bit raw data.
REQ-004 core_en SHALL equal (~last_stage.valid | source_ready); sink_ready SHALL equal core_en.
REQ-005 A beat SHALL be accepted when sink_valid & sink_ready; the pipe SHALL shift only when core_en=1, and a bubble SHALL enter when no beat is accepted.
REQ-006 Outputs SHALL be driven from the last stage: source_valid = valid; source_sop and source_eop = the stage's sop and eop; source_data = bypass ? raw : core_out_data.
REQ-007 Unstalled latency SHALL be exactly CORE_LAT cycles from acceptance to source_valid; a held source_ready=0 SHALL freeze all stages and keep source_* stable.
REQ-008 The packet FSM SHALL have states WAIT_SOP, VIDEO and OTHER.
REQ-009 In WAIT_SOP, accepted beats without sop SHALL be consumed and not forwarded (valid=0 enters the pipe).
REQ-010 Any accepted sop beat SHALL be forwarded as the header with bypass=1.
REQ-011 On a sop beat, the FSM SHALL go to VIDEO if sink_data[3:0]==0, otherwise to OTHER.
REQ-012 cfg_enable SHALL be latched on the video sop beat; pixels in that packet SHALL have bypass = ~latched value.
REQ-013 All OTHER-packet beats SHALL have bypass=1.
REQ-014 An accepted eop beat SHALL be forwarded and return the FSM to WAIT_SOP; a sop+eop single-beat packet SHALL be forwarded and leave the FSM in WAIT_SOP.
REQ-015 In VIDEO, counters x (11 bit) and y (11 bit) SHALL count accepted non-header beats.
- x wraps at IMAGE_W-1 and increments y.
- y saturates at IMAGE_H; the total count saturates at IMAGE_W*IMAGE_H+1.
REQ-016 On a video eop, frame_done SHALL pulse; frame_err SHALL also pulse if the pixel count != IMAGE_W*IMAGE_H.
REQ-017 A sop accepted while in VIDEO SHALL pulse frame_err and start the new packet per REQ-010 and REQ-011.
- The prior packet is not terminated; no eop is synthesized.
REQ-018 A sop in OTHER without a prior eop SHALL restart silently.
REQ-019 Over-length video frames SHALL still forward every beat.
REQ-020 Pulses SHALL be registered and asserted in the cycle after the triggering acceptance.
REQ-021 Latched cfg_enable SHALL be unaffected by cfg_enable changes mid-packet.

Reset
REQ-022 Reset SHALL clear all pipe valid bits, the counters and the latched cfg_enable.
- FSM returns to WAIT_SOP.
- source_valid, source_sop, source_eop, frame_done and frame_err = 0.
- source_data is don't-care.
REQ-023 Reset mid-packet SHALL discard in-flight beats; the next accepted non-sop beat SHALL be dropped per REQ-009.

Structure
REQ-024 A shared package hsv_pkg SHALL hold the FSM state enum, the sideband stage struct and the video packet-type constant 4'h0.
REQ-025 The sideband pipe SHALL be a sub-module hsv_sideband_pipe, parameterized by CORE_LAT.
REQ-026 The HSV core SHALL remain external; this block contains no colour arithmetic.

Verification
REQ-027 CORE_LAT=3, source_ready=1, cfg_enable=1: header 0x000000 followed by pixel 0xFF0000.
- Header out 3 cycles after acceptance with bypass.
- Pixel out as core_out_data 3 cycles after acceptance.
REQ-028 Full 640x480 frame with a correct eop -> frame_done=1, frame_err=0; 3-beat packet with header nibble 0xF -> all 3 beats bit-exact pass-through.
REQ-029 Hold source_ready=0 for 10 cycles mid-frame -> sink_ready=0 and core_en=0 in the same cycle; no beat is lost or duplicated.
REQ-030 Video frame with 307199 pixels -> frame_err pulse at eop; a sop mid-video -> frame_err pulse and the new header is forwarded.
REQ-031 Assert reset with 2 beats in flight -> source_valid=0 immediately; a subsequent non-sop beat is dropped.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared types for the HSV stream controller: packet FSM states, the sideband
// stage record that travels alongside the external core, and the video packet type.
package hsv_pkg;

    typedef enum logic [1:0] {
        WAIT_SOP,
        VIDEO,
        OTHER
    } pkt_state_t;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic        bypass;
        logic [23:0] data;
    } stage_t;

    localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

endpackage

// File: rtl/hsv_sideband_pipe.sv
// Sideband delay line matched to the external HSV core: it advances on the same
// enable, so stage CORE_LAT-1 always describes the beat the core is presenting.
module hsv_sideband_pipe
    import hsv_pkg::*;
#(
    parameter int CORE_LAT = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  stage_t stage_in,
    output stage_t stage_out
);

    stage_t pipe [CORE_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else if (en) begin
            pipe[0] <= stage_in;
            for (int i = 1; i < CORE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign stage_out = pipe[CORE_LAT-1];

endmodule

// File: rtl/hsv_stream_ctrl.sv
// Avalon-ST wrapper around an external RGB->HSV core: packet classification,
// per-beat bypass selection, backpressure and video frame size checking.
module hsv_stream_ctrl
    import hsv_pkg::*;
#(
    parameter int IMAGE_W  = 640,
    parameter int IMAGE_H  = 480,
    parameter int CORE_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    output logic        core_en,
    output logic [23:0] core_in_data,
    input  logic [23:0] core_out_data,
    input  logic        cfg_enable,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int PIX_TOTAL = IMAGE_W * IMAGE_H;
    localparam int CNT_W     = $clog2(PIX_TOTAL + 2);

    pkt_state_t       state;
    logic             cfg_latched;
    logic [10:0]      x_cnt;
    logic [10:0]      y_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_cnt_next;
    logic             frame_done_q;
    logic             frame_err_q;
    logic             accept;
    logic             is_video_hdr;
    stage_t           stage_in;
    stage_t           stage_last;

    assign core_en      = ~stage_last.valid | source_ready;
    assign sink_ready   = core_en;
    assign core_in_data = sink_data;
    assign accept       = sink_valid & core_en;
    assign is_video_hdr = (sink_data[3:0] == VIDEO_PKT_TYPE);

    // Saturate one past a full frame so over-length frames still read as wrong.
    assign pix_cnt_next = (pix_cnt == CNT_W'(PIX_TOTAL + 1)) ? pix_cnt : pix_cnt + CNT_W'(1);

    // Stage entering the pipe; beats outside any packet become bubbles.
    always_comb begin
        stage_in.valid  = accept;
        stage_in.sop    = sink_sop;
        stage_in.eop    = sink_eop;
        stage_in.bypass = 1'b1;
        stage_in.data   = sink_data;
        if (!sink_sop) begin
            case (state)
                WAIT_SOP: stage_in.valid  = 1'b0;
                VIDEO:    stage_in.bypass = ~cfg_latched;
                default:  stage_in.bypass = 1'b1;
            endcase
        end
    end

    hsv_sideband_pipe #(
        .CORE_LAT (CORE_LAT)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .en        (core_en),
        .stage_in  (stage_in),
        .stage_out (stage_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_SOP;
            cfg_latched  <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            pix_cnt      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (accept) begin
                if (sink_sop) begin
                    // A new header while a video frame is open abandons that frame.
                    if (state == VIDEO) begin
                        frame_err_q <= 1'b1;
                    end
                    x_cnt   <= '0;
                    y_cnt   <= '0;
                    pix_cnt <= '0;
                    if (sink_eop) begin
                        state <= WAIT_SOP;
                    end else if (is_video_hdr) begin
                        state       <= VIDEO;
                        cfg_latched <= cfg_enable;
                    end else begin
                        state <= OTHER;
                    end
                end else begin
                    case (state)
                        VIDEO: begin
                            pix_cnt <= pix_cnt_next;
                            if (x_cnt == 11'(IMAGE_W - 1)) begin
                                x_cnt <= '0;
                                if (y_cnt != 11'(IMAGE_H)) begin
                                    y_cnt <= y_cnt + 11'd1;
                                end
                            end else begin
                                x_cnt <= x_cnt + 11'd1;
                            end
                            if (sink_eop) begin
                                state        <= WAIT_SOP;
                                frame_done_q <= 1'b1;
                                if (pix_cnt_next != CNT_W'(PIX_TOTAL)) begin
                                    frame_err_q <= 1'b1;
                                end
                            end
                        end
                        OTHER: begin
                            if (sink_eop) begin
                                state <= WAIT_SOP;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign source_valid = stage_last.valid;
    assign source_sop   = stage_last.sop;
    assign source_eop   = stage_last.eop;
    assign source_data  = stage_last.bypass ? stage_last.data : core_out_data;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

endmodule
